// File: rtl/router_input_fifo_if.sv
// Flit link between upstream, router input FIFO and the output-port arbiters.
// The master modport is the upstream/arbiter side; the slave modport is the FIFO.
interface router_input_fifo_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CNT_W      = 3
);
  logic                  DRTS;
  logic [DATA_WIDTH-1:0] RX;
  logic                  CTS;
  logic [4:0]            grant_vec;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  empty;
  logic                  full;
  logic [CNT_W-1:0]      count;
  logic                  err_multi_grant;
  logic                  err_underflow;

  modport master (
    output DRTS, RX, grant_vec,
    input  CTS, data_out, empty, full, count, err_multi_grant, err_underflow
  );

  modport slave (
    input  DRTS, RX, grant_vec,
    output CTS, data_out, empty, full, count, err_multi_grant, err_underflow
  );
endinterface

// File: rtl/router_input_fifo.sv
// Per-input-port first-word-fall-through flit buffer with RTS/CTS write handshake
// and a one-pop-per-cycle read driven by any arbiter grant.
module router_input_fifo #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4,
  parameter int CNT_W      = 3
) (
  input  logic               clk,
  input  logic               rst,
  router_input_fifo_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [CNT_W-1:0]      count_q;
  logic                  cts_q;
  logic                  err_mg_q;
  logic                  err_uf_q;
  logic                  wr_en;
  logic                  rd_en;
  logic                  empty_c;
  logic                  full_c;

  function automatic logic [CNT_W-1:0] next_count(
    input logic [CNT_W-1:0] cur,
    input logic             wr,
    input logic             rd
  );
    case ({wr, rd})
      2'b10:   return cur + CNT_W'(1);
      2'b01:   return cur - CNT_W'(1);
      default: return cur;
    endcase
  endfunction

  function automatic logic multi_hot(input logic [4:0] v);
    return $countones(v) > 1;
  endfunction

  assign empty_c = (count_q == '0);
  assign full_c  = (count_q == CNT_W'(DEPTH));
  // The CTS cycle is the write cycle; a pop on an empty buffer is suppressed.
  assign wr_en   = cts_q;
  assign rd_en   = (|bus.grant_vec) & ~empty_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      cts_q    <= 1'b0;
      err_mg_q <= 1'b0;
      err_uf_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      // Never high two cycles running, so upstream sees one pulse per flit.
      cts_q    <= bus.DRTS & ~cts_q & ~full_c;
      err_mg_q <= multi_hot(bus.grant_vec);
      err_uf_q <= (|bus.grant_vec) & empty_c;
      count_q  <= next_count(count_q, wr_en, rd_en);
      if (wr_en) begin
        mem[wr_ptr] <= bus.RX;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (rd_en) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

  assign bus.CTS             = cts_q;
  assign bus.data_out        = mem[rd_ptr];
  assign bus.empty           = empty_c;
  assign bus.full            = full_c;
  assign bus.count           = count_q;
  assign bus.err_multi_grant = err_mg_q;
  assign bus.err_underflow   = err_uf_q;
endmodule

// File: tb/tb_router_input_fifo.sv
// Directed bench for router_input_fifo: a cycle-by-cycle vector table plus a
// hand-written fill/drain sequence with an upstream model.
module tb_router_input_fifo;
  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  router_input_fifo_if #(.DATA_WIDTH(32), .CNT_W(3)) bus ();

  router_input_fifo #(.DATA_WIDTH(32), .DEPTH(4), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        drts;
    logic [31:0] rx;
    logic [4:0]  g;
    logic        cts;
    logic [2:0]  cnt;
    logic        emp;
    logic        ful;
    logic [31:0] dout;
    logic        emg;
    logic        euf;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t v(logic r, logic d, logic [31:0] rx, logic [4:0] g,
                             logic cts, logic [2:0] cnt, logic e, logic f,
                             logic [31:0] dout, logic emg, logic euf);
    vec_t t;
    t.rst = r; t.drts = d; t.rx = rx; t.g = g;
    t.cts = cts; t.cnt = cnt; t.emp = e; t.ful = f;
    t.dout = dout; t.emg = emg; t.euf = euf;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  localparam logic [31:0] F1 = 32'hA5A5_0001, F2 = 32'hA5A5_0002, F3 = 32'hA5A5_0003;
  localparam logic [31:0] F4 = 32'hA5A5_0004, F5 = 32'hA5A5_0005;
  localparam logic [31:0] G1 = 32'h1111_0001, G2 = 32'h2222_0002, G3 = 32'h3333_0003;
  localparam logic [31:0] G4 = 32'h4444_0004, G5 = 32'h5555_0005, G6 = 32'h6666_0006;

  initial begin
    logic [31:0] h [4];
    logic [31:0] exp_q[$];
    logic [31:0] cur;
    logic        was_cts;
    int          idx;
    int          pulses;

    h[0] = 32'h7777_0007; h[1] = 32'h8888_0008; h[2] = 32'h9999_0009; h[3] = 32'hAAAA_000A;

    //              rst drts rx  grant     cts cnt e  f  dout emg euf
    tbl.push_back(v(1, 0, 0,  5'b00000, 0, 0, 1, 0, 0,  0, 0)); // reset state
    tbl.push_back(v(0, 1, F1, 5'b00000, 1, 0, 1, 0, 0,  0, 0)); // CTS one cycle after DRTS
    tbl.push_back(v(0, 1, F1, 5'b00000, 0, 1, 0, 0, F1, 0, 0)); // F1 visible at once
    tbl.push_back(v(0, 1, F2, 5'b00000, 1, 1, 0, 0, F1, 0, 0));
    tbl.push_back(v(0, 1, F2, 5'b00000, 0, 2, 0, 0, F1, 0, 0));
    tbl.push_back(v(0, 1, F3, 5'b00000, 1, 2, 0, 0, F1, 0, 0));
    tbl.push_back(v(0, 1, F3, 5'b00000, 0, 3, 0, 0, F1, 0, 0));
    tbl.push_back(v(0, 1, F4, 5'b00000, 1, 3, 0, 0, F1, 0, 0));
    tbl.push_back(v(0, 1, F4, 5'b00000, 0, 4, 0, 1, F1, 0, 0)); // full
    tbl.push_back(v(0, 1, F5, 5'b00000, 0, 4, 0, 1, F1, 0, 0)); // 5th flit blocked
    tbl.push_back(v(0, 1, F5, 5'b00000, 0, 4, 0, 1, F1, 0, 0));
    tbl.push_back(v(0, 0, 0,  5'b00100, 0, 3, 0, 0, F2, 0, 0)); // drain in order
    tbl.push_back(v(0, 0, 0,  5'b00100, 0, 2, 0, 0, F3, 0, 0));
    tbl.push_back(v(0, 0, 0,  5'b00100, 0, 1, 0, 0, F4, 0, 0));
    tbl.push_back(v(0, 0, 0,  5'b00100, 0, 0, 1, 0, F1, 0, 0)); // rd_ptr wrapped to 0
    tbl.push_back(v(0, 0, 0,  5'b00000, 0, 0, 1, 0, F1, 0, 0));
    tbl.push_back(v(0, 0, 0,  5'b00001, 0, 0, 1, 0, F1, 0, 1)); // underflow pulse
    tbl.push_back(v(0, 0, 0,  5'b00000, 0, 0, 1, 0, F1, 0, 0));
    tbl.push_back(v(0, 1, G1, 5'b00000, 1, 0, 1, 0, F1, 0, 0));
    tbl.push_back(v(0, 1, G1, 5'b00000, 0, 1, 0, 0, G1, 0, 0));
    tbl.push_back(v(0, 1, G2, 5'b00000, 1, 1, 0, 0, G1, 0, 0));
    tbl.push_back(v(0, 1, G2, 5'b00000, 0, 2, 0, 0, G1, 0, 0));
    tbl.push_back(v(0, 1, G3, 5'b00000, 1, 2, 0, 0, G1, 0, 0));
    tbl.push_back(v(0, 1, G3, 5'b00001, 0, 2, 0, 0, G2, 0, 0)); // write+pop: count holds
    tbl.push_back(v(0, 1, G4, 5'b00000, 1, 2, 0, 0, G2, 0, 0));
    tbl.push_back(v(0, 1, G4, 5'b00000, 0, 3, 0, 0, G2, 0, 0));
    tbl.push_back(v(0, 0, 0,  5'b10010, 0, 2, 0, 0, G3, 1, 0)); // multi-grant, one pop
    tbl.push_back(v(0, 0, 0,  5'b00000, 0, 2, 0, 0, G3, 0, 0));
    tbl.push_back(v(0, 1, G5, 5'b00000, 1, 2, 0, 0, G3, 0, 0));
    tbl.push_back(v(0, 1, G5, 5'b00000, 0, 3, 0, 0, G3, 0, 0));
    tbl.push_back(v(0, 1, G6, 5'b00000, 1, 3, 0, 0, G3, 0, 0)); // count=3, CTS=1
    tbl.push_back(v(1, 1, G6, 5'b00001, 0, 0, 1, 0, 0,  0, 0)); // mid-stream reset
    tbl.push_back(v(0, 1, G6, 5'b00000, 1, 0, 1, 0, 0,  0, 0)); // DRTS re-served
    tbl.push_back(v(0, 1, G6, 5'b00000, 0, 1, 0, 0, G6, 0, 0));

    foreach (tbl[i]) begin
      rst           = tbl[i].rst;
      bus.DRTS      = tbl[i].drts;
      bus.RX        = tbl[i].rx;
      bus.grant_vec = tbl[i].g;
      @(posedge clk);
      #1;
      chk($sformatf("v%0d.CTS", i),   32'(bus.CTS),             32'(tbl[i].cts));
      chk($sformatf("v%0d.count", i), 32'(bus.count),           32'(tbl[i].cnt));
      chk($sformatf("v%0d.empty", i), 32'(bus.empty),           32'(tbl[i].emp));
      chk($sformatf("v%0d.full", i),  32'(bus.full),            32'(tbl[i].ful));
      chk($sformatf("v%0d.data", i),  bus.data_out,             tbl[i].dout);
      chk($sformatf("v%0d.emg", i),   32'(bus.err_multi_grant), 32'(tbl[i].emg));
      chk($sformatf("v%0d.euf", i),   32'(bus.err_underflow),   32'(tbl[i].euf));
    end

    // Fill from count=1 with DRTS held and an upstream that advances RX after each CTS.
    exp_q.push_back(G6);
    idx     = 0;
    cur     = h[0];
    was_cts = 1'b0;
    pulses  = 0;
    for (int c = 0; c < 12; c++) begin
      bus.RX = cur;
      @(posedge clk);
      #1;
      if (was_cts) begin
        exp_q.push_back(cur);
        if (idx < 3) idx++;
        cur = h[idx];
      end
      chk("cts_no_repeat", 32'(was_cts & bus.CTS), 32'd0);
      if (bus.CTS) pulses++;
      was_cts = bus.CTS;
    end
    chk("fill_pulses", 32'(pulses), 32'd3);
    chk("fill_count", 32'(bus.count), 32'd4);
    chk("fill_full", 32'(bus.full), 32'd1);
    chk("fill_qsize", 32'(exp_q.size()), 32'd4);

    // Drain with the W grant and compare against the recorded order.
    bus.DRTS = 1'b0;
    for (int p = 0; p < 4; p++) begin
      chk($sformatf("drain%0d.data", p), bus.data_out, (p < exp_q.size()) ? exp_q[p] : 32'hDEAD_BEEF);
      bus.grant_vec = 5'b01000;
      @(posedge clk);
      #1;
      chk($sformatf("drain%0d.count", p), 32'(bus.count), 32'(3 - p));
    end
    chk("drain_empty", 32'(bus.empty), 32'd1);
    bus.grant_vec = 5'b00000;
    @(posedge clk);
    #1;
    chk("drain_no_underflow", 32'(bus.err_underflow), 32'd0);
    chk("drain_no_multi", 32'(bus.err_multi_grant), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
